// File: rtl/syscon_mtimer_pkg.sv
// Shared constants for the machine timer: register map, channel layout,
// control/config bit positions and the byte-enable merge helper.
package syscon_mtimer_pkg;

    localparam logic [7:0] REG_MTIME_LO = 8'h00;
    localparam logic [7:0] REG_MTIME_HI = 8'h04;
    localparam logic [7:0] REG_CTRL     = 8'h08;
    localparam logic [7:0] REG_PRESCALE = 8'h0C;
    localparam logic [7:0] REG_IRQ_PEND = 8'h10;
    localparam logic [7:0] REG_IRQ_EN   = 8'h14;

    localparam logic [7:0] CH_BASE   = 8'h20;
    localparam int         CH_STRIDE = 16;
    localparam int         CH_SHIFT  = $clog2(CH_STRIDE);

    // Word index of a register inside one channel block
    localparam logic [1:0] CH_CMP_LO = 2'd0;
    localparam logic [1:0] CH_CMP_HI = 2'd1;
    localparam logic [1:0] CH_PERIOD = 2'd2;
    localparam logic [1:0] CH_CFG    = 2'd3;

    localparam int CFG_EN_BIT  = 0;
    localparam int CFG_PER_BIT = 1;
    localparam int CTRL_EN_BIT = 0;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] sel_merge(input logic [31:0] oval,
                                              input logic [31:0] nval,
                                              input logic [3:0]  sel);
        logic [31:0] m;
        m = sel_mask(sel);
        return (oval & ~m) | (nval & m);
    endfunction

endpackage

// File: rtl/syscon_mtimer_chan.sv
// One compare channel: 64-bit compare value, reload period and config.
// Match is combinational from registered state; the top registers pend.
module syscon_mtimer_chan
    import syscon_mtimer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_mtime,
    input  logic        i_wr,
    input  logic [1:0]  i_idx,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_dat,
    output logic        o_match,
    output logic [31:0] o_rdat
);

    logic [63:0] cmp_q, cmp_d;
    logic [31:0] period_q, period_d;
    logic        en_q, en_d;
    logic        per_q, per_d;
    logic [31:0] cfg_cur;
    logic [31:0] wr_word;

    always_comb begin
        o_match  = en_q && (i_mtime >= cmp_q);
        cmp_d    = cmp_q;
        period_d = period_q;
        en_d     = en_q;
        per_d    = per_q;

        // A zero period cannot advance the compare, so it degrades to one-shot
        if (o_match) begin
            if (per_q && (period_q != '0)) begin
                cmp_d = cmp_q + {32'h0, period_q};
            end else begin
                en_d = 1'b0;
            end
        end

        cfg_cur              = '0;
        cfg_cur[CFG_EN_BIT]  = en_q;
        cfg_cur[CFG_PER_BIT] = per_q;

        case (i_idx)
            CH_CMP_LO: o_rdat = cmp_q[31:0];
            CH_CMP_HI: o_rdat = cmp_q[63:32];
            CH_PERIOD: o_rdat = period_q;
            default:   o_rdat = cfg_cur;
        endcase

        // Bus writes override any same-cycle match update
        wr_word = sel_merge(o_rdat, i_dat, i_sel);
        if (i_wr) begin
            case (i_idx)
                CH_CMP_LO: cmp_d[31:0]  = wr_word;
                CH_CMP_HI: cmp_d[63:32] = wr_word;
                CH_PERIOD: period_d     = wr_word;
                default: begin
                    en_d  = wr_word[CFG_EN_BIT];
                    per_d = wr_word[CFG_PER_BIT];
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmp_q    <= '1;
            period_q <= '0;
            en_q     <= 1'b0;
            per_q    <= 1'b0;
        end else begin
            cmp_q    <= cmp_d;
            period_q <= period_d;
            en_q     <= en_d;
            per_q    <= per_d;
        end
    end

endmodule

// File: rtl/syscon_mtimer.sv
// Machine timer top: prescaler, 64-bit mtime with coherent-read shadow,
// pending/enable interrupt registers and the Wishbone register interface.
module syscon_mtimer
    import syscon_mtimer_pkg::*;
#(
    parameter int N_CMP = 4,
    parameter int AW    = 8,
    parameter int PSW   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [AW-1:0]    i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    output logic [N_CMP-1:0] o_irq,
    output logic             o_timer_irq
);

    localparam int CW = AW - CH_SHIFT;

    logic             ack_q, ack_d;
    logic [31:0]      rdt_q, rdt_d;
    logic [PSW-1:0]   pcnt_q, pcnt_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [31:0]      shadow_q, shadow_d;
    logic             ctrl_en_q, ctrl_en_d;
    logic [PSW-1:0]   prescale_q, prescale_d;
    logic [N_CMP-1:0] pend_q, pend_d;
    logic [N_CMP-1:0] irq_en_q, irq_en_d;

    logic             req, wr_req, rd_req, tick, is_ch;
    logic [AW-1:0]    adr_w, ch_off;
    logic [CW-1:0]    ch_idx;
    logic [1:0]       ch_word;
    logic [31:0]      ch_rd, rd_val, wr_cur, wr_val, clr_bits;
    logic [63:0]      mtime_inc;
    logic [N_CMP-1:0] match, pend_clr;
    logic [31:0]      chan_rdat [N_CMP];
    logic             unused_bits;

    assign adr_w   = {i_wb_adr[AW-1:2], 2'b00};
    assign ch_off  = adr_w - AW'(CH_BASE);
    assign ch_idx  = ch_off[AW-1:CH_SHIFT];
    assign ch_word = ch_off[CH_SHIFT-1:2];
    assign is_ch   = (adr_w >= AW'(CH_BASE)) && (ch_idx < CW'(N_CMP));

    assign req    = i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr_req = req & i_wb_we;
    assign rd_req = req & ~i_wb_we;

    for (genvar gi = 0; gi < N_CMP; gi++) begin : g_chan
        syscon_mtimer_chan u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_mtime (mtime_q),
            .i_wr    (wr_req && is_ch && (ch_idx == CW'(gi))),
            .i_idx   (ch_word),
            .i_sel   (i_wb_sel),
            .i_dat   (i_wb_dat),
            .o_match (match[gi]),
            .o_rdat  (chan_rdat[gi])
        );
    end

    always_comb begin
        ch_rd = '0;
        for (int i = 0; i < N_CMP; i++) begin
            if (ch_idx == CW'(i)) ch_rd = chan_rdat[i];
        end

        rd_val = '0;
        if (is_ch) begin
            rd_val = ch_rd;
        end else begin
            case (adr_w)
                AW'(REG_MTIME_LO): rd_val = mtime_q[31:0];
                AW'(REG_MTIME_HI): rd_val = shadow_q;
                AW'(REG_CTRL):     rd_val = 32'(ctrl_en_q) << CTRL_EN_BIT;
                AW'(REG_PRESCALE): rd_val = 32'(prescale_q);
                AW'(REG_IRQ_PEND): rd_val = 32'(pend_q);
                AW'(REG_IRQ_EN):   rd_val = 32'(irq_en_q);
                default:           rd_val = '0;
            endcase
        end

        // Partial writes to MTIME_HI merge with live mtime, not the shadow
        wr_cur   = (adr_w == AW'(REG_MTIME_HI)) ? mtime_q[63:32] : rd_val;
        wr_val   = sel_merge(wr_cur, i_wb_dat, i_wb_sel);
        clr_bits = i_wb_dat & sel_mask(i_wb_sel);
    end

    always_comb begin
        tick   = ctrl_en_q && (pcnt_q >= prescale_q);
        pcnt_d = pcnt_q;
        if (ctrl_en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + PSW'(1);
        end

        mtime_inc  = mtime_q + 64'(tick);
        mtime_d    = mtime_inc;
        ctrl_en_d  = ctrl_en_q;
        prescale_d = prescale_q;
        irq_en_d   = irq_en_q;
        pend_clr   = '0;

        shadow_d = shadow_q;
        if (rd_req && (adr_w == AW'(REG_MTIME_LO))) begin
            shadow_d = mtime_q[63:32];
        end

        if (wr_req) begin
            case (adr_w)
                AW'(REG_MTIME_LO): mtime_d[31:0]  = wr_val;
                AW'(REG_MTIME_HI): mtime_d[63:32] = wr_val;
                AW'(REG_CTRL):     ctrl_en_d      = wr_val[CTRL_EN_BIT];
                AW'(REG_PRESCALE): prescale_d     = wr_val[PSW-1:0];
                AW'(REG_IRQ_PEND): pend_clr       = clr_bits[N_CMP-1:0];
                AW'(REG_IRQ_EN):   irq_en_d       = wr_val[N_CMP-1:0];
                default: ;
            endcase
        end

        // A match in the same cycle as a clear keeps the bit set
        pend_d = (pend_q & ~pend_clr) | match;
        ack_d  = req;
        rdt_d  = rd_req ? rd_val : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q      <= 1'b0;
            rdt_q      <= '0;
            pcnt_q     <= '0;
            mtime_q    <= '0;
            shadow_q   <= '0;
            ctrl_en_q  <= 1'b0;
            prescale_q <= '0;
            pend_q     <= '0;
            irq_en_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            rdt_q      <= rdt_d;
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            shadow_q   <= shadow_d;
            ctrl_en_q  <= ctrl_en_d;
            prescale_q <= prescale_d;
            pend_q     <= pend_d;
            irq_en_q   <= irq_en_d;
        end
    end

    assign o_wb_ack    = ack_q;
    assign o_wb_rdt    = rdt_q;
    assign o_irq       = pend_q & irq_en_q;
    assign o_timer_irq = |o_irq;

    assign unused_bits = ^{i_wb_adr[1:0], ch_off[1:0], clr_bits};

endmodule

// File: tb/tb_syscon_mtimer.sv
// Self-checking bench for syscon_mtimer: bus reads are scored against a
// queue of expected values; interrupt timing is checked cycle-exactly.
module tb_syscon_mtimer;

    localparam int N_CMP = 4;
    localparam int AW    = 8;
    localparam int PSW   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AW-1:0]    adr = '0;
    logic [31:0]      dat = '0;
    logic [3:0]       sel = '0;
    logic             we = 1'b0, cyc = 1'b0, stb = 1'b0;
    logic [31:0]      rdt;
    logic             ack;
    logic [N_CMP-1:0] irq;
    logic             timer_irq;

    int n_cmp = 0, n_bad = 0, cyc_n = 0, ack_cnt = 0, xfer_cnt = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    syscon_mtimer #(.N_CMP(N_CMP), .AW(AW), .PSW(PSW)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wb_adr    (adr),
        .i_wb_dat    (dat),
        .i_wb_sel    (sel),
        .i_wb_we     (we),
        .i_wb_cyc    (cyc),
        .i_wb_stb    (stb),
        .o_wb_rdt    (rdt),
        .o_wb_ack    (ack),
        .o_irq       (irq),
        .o_timer_irq (timer_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) if (ack) ack_cnt <= ack_cnt + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output logic ok);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        ok = 1'b0;
        r  = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                ok = 1'b1;
                r  = rdt;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (ok) xfer_cnt++;
        $display("wb %s adr=%02h dat=%08h sel=%b ack=%0d", w ? "wr" : "rd", a, w ? d : r, s, ok);
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] r;
        logic ok;
        wb_xfer(1'b1, a, d, s, r, ok);
        if (!ok) check_val("ack_timeout_wr", 0, 1);
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        logic ok;
        wb_xfer(1'b0, a, 32'h0, 4'hF, d, ok);
        if (!ok) check_val("ack_timeout_rd", 0, 1);
    endtask

    task automatic wb_read_chk(input logic [7:0] a, input logic [31:0] e, input string tag);
        logic [31:0] r, ex;
        string t;
        logic ok;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        wb_xfer(1'b0, a, 32'h0, 4'hF, r, ok);
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        if (ok) check_val(t, r, ex);
        else    check_val({t, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_until(input int target);
        while (cyc_n < target) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m0, m1, m2, lo1, lo2;
        int e0;
        logic [7:0] ra [7];
        ra = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ack", ack, 0);
        check_val("rst_rdt", rdt, 0);
        check_val("rst_irq", irq, 0);
        check_val("rst_timer_irq", timer_irq, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) wb_read_chk(ra[i], 32'h0, $sformatf("rst_reg_%02h", ra[i]));
        for (int n = 0; n < N_CMP; n++) begin
            wb_read_chk(8'(8'h20 + 16 * n),     32'hFFFF_FFFF, $sformatf("rst_ch%0d_cmplo", n));
            wb_read_chk(8'(8'h20 + 16 * n + 4), 32'hFFFF_FFFF, $sformatf("rst_ch%0d_cmphi", n));
            wb_read_chk(8'(8'h20 + 16 * n + 8), 32'h0,         $sformatf("rst_ch%0d_period", n));
            wb_read_chk(8'(8'h20 + 16 * n + 12), 32'h0,        $sformatf("rst_ch%0d_cfg", n));
        end
        check_val("rst_timer_irq_after", timer_irq, 0);

        // Prescaler: divide by 4, then freeze
        wb_write(8'h0C, 32'd3);
        wb_write(8'h08, 32'd1);
        wb_read(8'h00, m0);
        repeat (40) @(posedge clk);
        #1;
        wb_read(8'h00, m1);
        check_val("presc_delta_in_range", ((m1 - m0) >= 9) && ((m1 - m0) <= 11), 1);
        wb_write(8'h08, 32'd0);
        wb_read(8'h00, m2);
        repeat (20) @(posedge clk);
        #1;
        wb_read_chk(8'h00, m2, "frozen_lo");

        // Coherent 64-bit read across the low-word carry
        wb_write(8'h0C, 32'd0);
        wb_write(8'h04, 32'd0);
        wb_write(8'h00, 32'hFFFF_FFFE);
        wb_write(8'h08, 32'd1);
        wb_read(8'h00, lo1);
        check_val("coh_lo_prewrap", lo1 >= 32'hFFFF_FFFE, 1);
        wb_read_chk(8'h04, 32'h0, "coh_hi_shadow");
        wb_read(8'h00, lo2);
        check_val("coh_lo_postwrap", lo2 < 32'h0000_0100, 1);
        wb_read_chk(8'h04, 32'h1, "coh_hi_carry");
        wb_write(8'h08, 32'd0);

        // Channel 1 one-shot at mtime 50
        wb_write(8'h00, 32'd0);
        wb_write(8'h04, 32'd0);
        wb_write(8'h34, 32'd0);
        wb_write(8'h30, 32'd50);
        wb_write(8'h14, 32'h2);
        wb_write(8'h3C, 32'h1);
        wb_write(8'h08, 32'd1);
        e0 = cyc_n;
        wait_until(e0 + 50);
        check_val("ch1_irq_early", irq, 4'h0);
        wait_until(e0 + 51);
        check_val("ch1_irq_rise", irq, 4'h2);
        check_val("ch1_timer_irq", timer_irq, 1);
        wb_read_chk(8'h3C, 32'h0, "ch1_cfg_en_clr");
        wb_read_chk(8'h10, 32'h2, "ch1_pend");
        wb_write(8'h10, 32'h2);
        check_val("ch1_w1c", irq, 4'h0);
        repeat (20) @(posedge clk);
        #1;
        check_val("ch1_stays_low", irq, 4'h0);
        wb_write(8'h08, 32'd0);

        // Channel 0 periodic, period 10
        wb_write(8'h00, 32'd0);
        wb_write(8'h04, 32'd0);
        wb_write(8'h24, 32'd0);
        wb_write(8'h20, 32'd10);
        wb_write(8'h28, 32'd10);
        wb_write(8'h14, 32'h1);
        wb_write(8'h2C, 32'h3);
        wb_write(8'h08, 32'd1);
        e0 = cyc_n;
        for (int p = 1; p <= 3; p++) begin
            wait_until(e0 + 10 * p);
            check_val($sformatf("p0_early_%0d", p), irq, 4'h0);
            wait_until(e0 + 10 * p + 1);
            check_val($sformatf("p0_hit_%0d", p), irq, 4'h1);
            if (p < 3) begin
                wb_write(8'h10, 32'h1);
                check_val($sformatf("p0_clr_%0d", p), irq, 4'h0);
            end
        end
        wait_until(e0 + 39);
        wb_write(8'h10, 32'h1);
        check_val("p0_set_wins", irq, 4'h1);
        wb_read_chk(8'h20, 32'd50, "p0_cmp_adv");
        wb_read_chk(8'h2C, 32'h3, "p0_cfg_kept");
        wb_write(8'h08, 32'd0);
        wb_write(8'h2C, 32'h0);

        // Two channels on the same compare value
        wb_write(8'h10, 32'hF);
        wb_write(8'h14, 32'hC);
        wb_write(8'h00, 32'd0);
        wb_write(8'h04, 32'd0);
        wb_write(8'h44, 32'd0);
        wb_write(8'h40, 32'd100);
        wb_write(8'h4C, 32'h1);
        wb_write(8'h54, 32'd0);
        wb_write(8'h50, 32'd100);
        wb_write(8'h5C, 32'h1);
        wb_write(8'h08, 32'd1);
        e0 = cyc_n;
        wait_until(e0 + 100);
        check_val("dual_early", irq, 4'h0);
        wait_until(e0 + 101);
        check_val("dual_same_edge", irq, 4'hC);
        wb_write(8'h14, 32'h0);
        check_val("tirq_masked", timer_irq, 0);
        wb_read_chk(8'h10, 32'hC, "dual_pend");
        wb_write(8'h14, 32'h4);
        check_val("tirq_enabled", timer_irq, 1);
        check_val("irq_ch2_only", irq, 4'h4);

        // Byte enables
        wb_write(8'h10, 32'hFF, 4'b0010);
        wb_read_chk(8'h10, 32'hC, "pend_sel_mask");
        wb_write(8'h40, 32'hAABB_CCDD, 4'b0001);
        wb_read_chk(8'h40, 32'h0000_00DD, "cmp_byte0");
        wb_read_chk(8'h50, 32'd100, "cmp_other_ch");
        wb_write(8'h08, 32'd0);

        // Reset during an acked transfer drops ack at once
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h00;
        @(posedge clk); #1;
        check_val("mid_xfer_ack", ack, 1);
        rst_n = 1'b0;
        #1;
        check_val("rst_ack_drop", ack, 0);
        check_val("rst_irq_drop", irq, 4'h0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_read_chk(8'h14, 32'h0, "post_rst_irq_en");

        repeat (2) @(posedge clk);
        #1;
        check_val("ack_count", ack_cnt, xfer_cnt);
        check_val("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/syscon_mtimer.md
# syscon_mtimer

Parametrised machine-timer block for the system controller: a free-running 64-bit `mtime` with programmable prescaler and `N_CMP` independent compare channels, each one-shot or periodic, with sticky per-channel pending bits and a combined timer interrupt. It is a Wishbone slave on the peripheral bus alongside the existing system controller and drives the core's timer interrupt line.

## Interface
- `N_CMP`, default 4: number of compare channels, range 1..14.
- `AW`, default 8: decoded Wishbone address width (byte address).
- `PSW`, default 16: prescaler counter width.
- `i_clk` in 1: system clock. The block uses one clock; reset is asynchronous and active-low.
- `i_rst_n` in 1: asynchronous reset, active low.
- `i_wb_adr` in AW: byte address. Bits [1:0] are ignored.
- `i_wb_dat` in 32: write data.
- `i_wb_sel` in 4: byte enables for writes.
- `i_wb_we`, `i_wb_cyc`, `i_wb_stb` in 1 each: Wishbone classic controls.
- `o_wb_rdt` out 32: read data, registered.
- `o_wb_ack` out 1: acknowledge, registered.
- `o_irq` out N_CMP: per-channel interrupt, `pend & irq_en`.
- `o_timer_irq` out 1: OR-reduction of `o_irq`.

## Operation
- Register map (32-bit, byte offsets):
  - 0x00 `MTIME_LO`.
  - 0x04 `MTIME_HI`.
  - 0x08 `CTRL`: bit0 is the global enable.
  - 0x0C `PRESCALE`: [PSW-1:0].
  - 0x10 `IRQ_PEND`: write 1 to clear.
  - 0x14 `IRQ_EN`.
  - Channel n at 0x20+0x10·n: +0 `CMP_LO`, +4 `CMP_HI`, +8 `PERIOD` (32 bit), +C `CFG` (bit0 `en`, bit1 `periodic`).
  - Unmapped addresses read 0 and ignore writes, but are still acked.
- All writes honour `i_wb_sel` per byte. On `IRQ_PEND`, only bytes selected with a 1 clear.
- Prescaler:
  - While `CTRL.en` is 1, `pcnt` counts 0..`PRESCALE`. Reaching `PRESCALE` produces a one-cycle `tick` and resets `pcnt` to 0.
  - `PRESCALE`=0 gives a tick every cycle.
  - While `CTRL.en` is 0, `pcnt` and `mtime` hold their values.
- `mtime` increments by 1 on each `tick` and wraps from 2^64-1 to 0. A bus write to either half replaces that half, and the write wins over a same-cycle tick.
- Coherent 64-bit read: reading `MTIME_LO` latches `mtime[63:32]` into a shadow register. Reading `MTIME_HI` returns the shadow, not live `mtime`.
- Channel match condition: `en` && `mtime >= cmp` (64-bit unsigned). On match:
  - `pend[n]` is set.
  - If `periodic` and `PERIOD`≠0: `cmp` becomes `cmp + PERIOD` (64-bit, wrapping) and `en` stays 1.
  - Otherwise `en` is cleared (one-shot). `periodic` with `PERIOD`=0 behaves as one-shot.
- `pend` is sticky. If a set and a W1C occur in the same cycle, the set wins.
- Writing `CMP_LO`, `CMP_HI` or `CFG` does not touch `pend`.

## Timing
- Reset values:
  - `o_wb_ack`=0, `o_wb_rdt`=0, `o_irq`=0, `o_timer_irq`=0.
  - All registers are 0 except `CMP` and the shadow: `CMP`=all-ones, shadow=0.
- Bus handshake:
  - `o_wb_ack` rises in the cycle after `cyc&stb` while `ack` is 0, and lasts exactly one cycle.
  - A held strobe therefore gets an ack every second cycle.
  - Write side-effects take effect on the same edge that raises `ack`. Read data is valid with `ack`.
- Match latency:
  - The compare uses registered `mtime` and `cmp`. `pend` is set on the edge after the cycle in which the condition is true.
  - `o_irq` is combinational from registered `pend` and `irq_en`, so there is no added latency.
  - In periodic mode, the `cmp` update happens on the same edge as the `pend` set. If the new `cmp` is still ≤ `mtime` (missed periods), the channel matches again in the next cycle.
- Reset asserted mid-transfer: `ack` drops immediately and the transfer is lost.
- `mtime` wrap with `cmp` near 2^64-1: no special handling. The compare is plain unsigned, so a channel armed with a large `cmp` that `mtime` has already passed fires at once.

## Structure
- Package `syscon_mtimer_pkg`:
  - Register offset constants.
  - Channel stride (0x10) and channel base (0x20).
  - `CFG` bit positions.
  - `CTRL` bit positions.
- Sub-module `syscon_mtimer_chan`, one instance per channel:
  - Holds `cmp`, `PERIOD` and `CFG`.
  - Takes `mtime`, a write strobe, `sel` and data.
  - Outputs a match pulse and readback.
- The top level holds the prescaler, `mtime`, the shadow, `pend`/`irq_en`, address decode and the read mux.

## Test plan
- Reset, then read every register → all 0 except `CMP_LO`/`CMP_HI`=0xFFFFFFFF. `o_timer_irq`=0. Each access is acked exactly once.
- `PRESCALE`=3, `CTRL`=1, wait 40 cycles → `mtime` advanced by 10 (±1). With `CTRL`=0, `mtime` stays frozen over 20 cycles.
- Write `MTIME`=0x0000_0000_FFFF_FFFE with `PRESCALE`=0, read LO then HI → HI is the value latched at the LO read, not live `mtime`. Carry into HI is observed on a later LO/HI pair.
- Channel 1 one-shot: `CMP`=50, `IRQ_EN`=0x2 → `o_irq[1]` rises one cycle after `mtime`=50 and `CFG.en` reads 0. W1C 0x2 drops `o_irq`, and it stays low.
- Channel 0 periodic: `CMP`=10, `PERIOD`=10 → pend at `mtime` 10, 20 and 30 after each W1C. A W1C issued on the same cycle as a match leaves `pend`=1.
- Two channels with an identical `CMP` → both `pend` bits are set on the same edge, and `o_timer_irq` asserts only after its `IRQ_EN` bit is set. Byte-masked write `sel`=0b0001 to `CMP_LO` changes only byte 0.
